// File: rtl/ecc_127_bist_arb_if.sv
// Functional read port plus the shared ecc_127 decoder connection, as seen by the BIST arbiter.
interface ecc_127_bist_arb_if #(
  parameter int unsigned DATA_WIDTH   = 127,
  parameter int unsigned PARITY_WIDTH = 9
);
  logic                    func_vld;
  logic                    func_rdy;
  logic [DATA_WIDTH-1:0]   func_data;
  logic [PARITY_WIDTH-1:0] func_parity;
  logic                    func_bypass;
  logic                    func_out_vld;
  logic [DATA_WIDTH-1:0]   func_out_data;
  logic                    func_out_sbit;
  logic                    func_out_dbit;
  logic                    func_out_fault;

  logic [DATA_WIDTH-1:0]   dec_data_in;
  logic [PARITY_WIDTH-1:0] dec_parity_in;
  logic                    dec_bypass;
  logic                    dec_fdet_en;
  logic [DATA_WIDTH-1:0]   dec_data_out;
  logic                    dec_ecc_fault;
  logic                    dec_sbit_err;
  logic                    dec_dbit_err;

  modport slave (
    input  func_vld, func_data, func_parity, func_bypass,
    input  dec_data_out, dec_ecc_fault, dec_sbit_err, dec_dbit_err,
    output func_rdy, func_out_vld, func_out_data, func_out_sbit, func_out_dbit, func_out_fault,
    output dec_data_in, dec_parity_in, dec_bypass, dec_fdet_en
  );

  modport master (
    output func_vld, func_data, func_parity, func_bypass,
    output dec_data_out, dec_ecc_fault, dec_sbit_err, dec_dbit_err,
    input  func_rdy, func_out_vld, func_out_data, func_out_sbit, func_out_dbit, func_out_fault,
    input  dec_data_in, dec_parity_in, dec_bypass, dec_fdet_en
  );
endinterface

// File: rtl/ecc_127_bist_arb.sv
// Shares one ecc_127 decoder between functional reads and a clean/single/double-bit BIST sequence.
// Functional traffic wins; BIST steps take idle slots or preempt once starved.
module ecc_127_bist_arb #(
  parameter int unsigned DATA_WIDTH   = 127,
  parameter int unsigned PARITY_WIDTH = 9,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cfg_bist_en,
  input  logic [CNT_WIDTH-1:0]    i_cfg_period,
  input  logic [CNT_WIDTH-1:0]    i_cfg_starve_lim,
  input  logic                    i_cfg_fdet_en,
  input  logic [DATA_WIDTH-1:0]   i_cfg_gold_data,
  input  logic [PARITY_WIDTH-1:0] i_cfg_gold_parity,
  input  logic                    i_bist_start,
  ecc_127_bist_arb_if.slave       bus,
  output logic                    o_bist_busy,
  output logic                    o_bist_fail,
  output logic [1:0]              o_bist_fail_step,
  output logic [CNT_WIDTH-1:0]    o_bist_pass_cnt
);
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PEND  = 3'd1,
    ST_CLEAN = 3'd2,
    ST_SBIT  = 3'd3,
    ST_DBIT  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_period_cnt;
  logic [CNT_WIDTH-1:0]  r_starve_cnt;
  logic [CNT_WIDTH-1:0]  r_pass_cnt;
  logic [BIT_W-1:0]      r_bit;
  logic [BIT_W-1:0]      w_bit_nxt;
  logic                  r_run_bad;
  logic                  r_fail;
  logic [1:0]            r_fail_step;
  logic [1:0]            w_step_code;
  logic                  r_out_vld;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_sbit;
  logic                  r_out_dbit;
  logic                  r_out_fault;

  logic                  w_step_state;
  logic                  w_starved;
  logic                  w_step;
  logic                  w_func_rdy;
  logic                  w_func_acc;
  logic                  w_period_hit;
  logic                  w_mismatch;
  logic [DATA_WIDTH-1:0] w_flip1;
  logic [DATA_WIDTH-1:0] w_flip2;

  // Grant: a step runs on a free slot, or unconditionally once starved (functional port stalls).
  assign w_step_state = (r_state == ST_CLEAN) || (r_state == ST_SBIT) || (r_state == ST_DBIT);
  assign w_starved    = (r_starve_cnt >= i_cfg_starve_lim);
  assign w_step       = i_cfg_bist_en && w_step_state && (!bus.func_vld || w_starved);
  assign w_func_rdy   = !(i_cfg_bist_en && w_step_state && w_starved);
  assign w_func_acc   = bus.func_vld && w_func_rdy;
  assign w_period_hit = (r_state == ST_IDLE) && (i_cfg_period != '0) &&
                        (r_period_cnt >= i_cfg_period - CNT_WIDTH'(1));

  assign w_bit_nxt = (r_bit == BIT_W'(DATA_WIDTH - 1)) ? '0 : r_bit + BIT_W'(1);
  assign w_flip1   = DATA_WIDTH'(1) << r_bit;
  assign w_flip2   = DATA_WIDTH'(1) << w_bit_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_bist_start || w_period_hit) w_state_nxt = ST_PEND;
      ST_PEND:  w_state_nxt = ST_CLEAN;
      ST_CLEAN: if (w_step) w_state_nxt = ST_SBIT;
      ST_SBIT:  if (w_step) w_state_nxt = ST_DBIT;
      ST_DBIT:  if (w_step) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (!i_cfg_bist_en) w_state_nxt = ST_IDLE;
  end

  // Decoder mux and step checker; the decoder is combinational so the check sees this cycle's response.
  always_comb begin
    bus.dec_data_in   = bus.func_data;
    bus.dec_parity_in = bus.func_parity;
    bus.dec_bypass    = bus.func_bypass;
    bus.dec_fdet_en   = i_cfg_fdet_en;
    bus.func_rdy      = w_func_rdy;
    o_bist_busy       = (r_state != ST_IDLE);
    w_mismatch        = 1'b0;
    w_step_code       = 2'd0;
    if (w_step) begin
      bus.dec_parity_in = i_cfg_gold_parity;
      bus.dec_bypass    = 1'b0;
      bus.dec_fdet_en   = 1'b1;
      case (r_state)
        ST_CLEAN: begin
          bus.dec_data_in = i_cfg_gold_data;
          w_mismatch = bus.dec_sbit_err || bus.dec_dbit_err || bus.dec_ecc_fault ||
                       (bus.dec_data_out != i_cfg_gold_data);
        end
        ST_SBIT: begin
          bus.dec_data_in = i_cfg_gold_data ^ w_flip1;
          w_step_code = 2'd1;
          w_mismatch = !bus.dec_sbit_err || bus.dec_dbit_err || bus.dec_ecc_fault ||
                       (bus.dec_data_out != i_cfg_gold_data);
        end
        default: begin
          bus.dec_data_in = i_cfg_gold_data ^ w_flip1 ^ w_flip2;
          w_step_code = 2'd2;
          w_mismatch = !bus.dec_dbit_err || bus.dec_sbit_err || bus.dec_ecc_fault;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
      r_starve_cnt <= '0;
      r_pass_cnt   <= '0;
      r_bit        <= '0;
      r_run_bad    <= 1'b0;
      r_fail       <= 1'b0;
      r_fail_step  <= 2'd0;
    end else begin
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_IDLE) && i_cfg_bist_en && (i_cfg_period != '0))
        r_period_cnt <= r_period_cnt + CNT_WIDTH'(1);
      else
        r_period_cnt <= '0;

      if (w_state_nxt == ST_IDLE)
        r_starve_cnt <= '0;
      else if ((r_state != ST_IDLE) && !w_step && (r_starve_cnt != '1))
        r_starve_cnt <= r_starve_cnt + CNT_WIDTH'(1);

      if (r_state == ST_IDLE)
        r_run_bad <= 1'b0;
      else if (w_step && w_mismatch)
        r_run_bad <= 1'b1;

      if (w_step && w_mismatch) begin
        r_fail <= 1'b1;
        if (!r_fail) r_fail_step <= w_step_code;
      end

      // Run completion: advance the walking bit and credit a clean run.
      if (w_step && (r_state == ST_DBIT)) begin
        r_bit <= w_bit_nxt;
        if (!r_run_bad && !w_mismatch && (r_pass_cnt != '1))
          r_pass_cnt <= r_pass_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_out_sbit  <= 1'b0;
      r_out_dbit  <= 1'b0;
      r_out_fault <= 1'b0;
    end else begin
      r_out_vld <= w_func_acc;
      if (w_func_acc) begin
        r_out_data  <= bus.dec_data_out;
        r_out_sbit  <= bus.dec_sbit_err;
        r_out_dbit  <= bus.dec_dbit_err;
        r_out_fault <= bus.dec_ecc_fault;
      end
    end
  end

  assign bus.func_out_vld   = r_out_vld;
  assign bus.func_out_data  = r_out_data;
  assign bus.func_out_sbit  = r_out_sbit;
  assign bus.func_out_dbit  = r_out_dbit;
  assign bus.func_out_fault = r_out_fault;
  assign o_bist_fail        = r_fail;
  assign o_bist_fail_step   = r_fail_step;
  assign o_bist_pass_cnt    = r_pass_cnt;
endmodule
